// File: rtl/stopwatch_counter_if.sv
// Control and display-side signals of the stopwatch timekeeping core.
// The master drives the controls; the slave (the counter) drives the digits and flags.
interface stopwatch_counter_if;
  logic       tick_1hz;
  logic       tick_adj;
  logic       adj;
  logic       sel;
  logic       pause_pulse;
  logic       clear_pulse;
  logic [3:0] digit_1;
  logic [3:0] digit_2;
  logic [3:0] digit_3;
  logic [3:0] digit_4;
  logic       reg_mode;
  logic       adj_sec_mode;
  logic       adj_min_mode;
  logic       pause_mode;
  logic       wrap;

  modport master (
    output tick_1hz, tick_adj, adj, sel, pause_pulse, clear_pulse,
    input  digit_1, digit_2, digit_3, digit_4,
    input  reg_mode, adj_sec_mode, adj_min_mode, pause_mode, wrap
  );

  modport slave (
    input  tick_1hz, tick_adj, adj, sel, pause_pulse, clear_pulse,
    output digit_1, digit_2, digit_3, digit_4,
    output reg_mode, adj_sec_mode, adj_min_mode, pause_mode, wrap
  );
endinterface

// File: rtl/stopwatch_counter.sv
// MM:SS BCD timekeeping core: counts on tick_1hz, per-field adjust on tick_adj,
// pause toggle, soft clear, and registered mode/wrap flags for the display stage.
module stopwatch_counter (
  input logic              clk,
  input logic              rst_n,
  stopwatch_counter_if.slave bus
);

  logic [3:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic       paused_q, paused_d;
  logic       wrap_q, wrap_d;
  logic       reg_mode_q, adj_sec_mode_q, adj_min_mode_q;

  logic       sec_at_max, min_at_max;
  logic       do_adjust, do_count;

  // Modulo-60 increment of a two-digit BCD field; out-of-range digits fold back to 0.
  function automatic logic [7:0] inc_mod60(input logic [3:0] tens, input logic [3:0] ones);
    logic [3:0] t_n, o_n;
    if (ones >= 4'd9) begin
      o_n = 4'd0;
      t_n = (tens >= 4'd5) ? 4'd0 : tens + 4'd1;
    end else begin
      o_n = ones + 4'd1;
      t_n = (tens > 4'd5) ? 4'd0 : tens;
    end
    return {t_n, o_n};
  endfunction

  assign sec_at_max = (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);
  assign min_at_max = (min_tens_q == 4'd5) && (min_ones_q == 4'd9);
  assign do_adjust  = bus.adj && bus.tick_adj;
  assign do_count   = !bus.adj && !paused_q && bus.tick_1hz;

  always_comb begin
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    wrap_d     = 1'b0;
    // Pause toggles independently of clear/adjust/count; counting sees the old value.
    paused_d   = paused_q ^ bus.pause_pulse;

    if (bus.clear_pulse) begin
      min_tens_d = 4'd0;
      min_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      sec_ones_d = 4'd0;
    end else if (do_adjust) begin
      if (bus.sel) begin
        {sec_tens_d, sec_ones_d} = inc_mod60(sec_tens_q, sec_ones_q);
      end else begin
        {min_tens_d, min_ones_d} = inc_mod60(min_tens_q, min_ones_q);
      end
    end else if (do_count) begin
      {sec_tens_d, sec_ones_d} = inc_mod60(sec_tens_q, sec_ones_q);
      if (sec_at_max) begin
        {min_tens_d, min_ones_d} = inc_mod60(min_tens_q, min_ones_q);
        wrap_d = min_at_max;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_tens_q     <= 4'd0;
      min_ones_q     <= 4'd0;
      sec_tens_q     <= 4'd0;
      sec_ones_q     <= 4'd0;
      paused_q       <= 1'b0;
      wrap_q         <= 1'b0;
      reg_mode_q     <= 1'b1;
      adj_sec_mode_q <= 1'b0;
      adj_min_mode_q <= 1'b0;
    end else begin
      min_tens_q     <= min_tens_d;
      min_ones_q     <= min_ones_d;
      sec_tens_q     <= sec_tens_d;
      sec_ones_q     <= sec_ones_d;
      paused_q       <= paused_d;
      wrap_q         <= wrap_d;
      reg_mode_q     <= ~bus.adj;
      adj_sec_mode_q <= bus.adj & bus.sel;
      adj_min_mode_q <= bus.adj & ~bus.sel;
    end
  end

  assign bus.digit_1      = min_tens_q;
  assign bus.digit_2      = min_ones_q;
  assign bus.digit_3      = sec_tens_q;
  assign bus.digit_4      = sec_ones_q;
  assign bus.pause_mode   = paused_q;
  assign bus.wrap         = wrap_q;
  assign bus.reg_mode     = reg_mode_q;
  assign bus.adj_sec_mode = adj_sec_mode_q;
  assign bus.adj_min_mode = adj_min_mode_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: counting, wrap, pause, adjust, clear and async reset.
module tb_stopwatch_counter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  stopwatch_counter_if sw_if ();

  stopwatch_counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge: holds the pulses across one rising edge, returns at the next
  // falling edge with the pulses dropped and the results visible.
  task automatic step(input logic t1, input logic ta, input logic pp, input logic cp);
    sw_if.tick_1hz    = t1;
    sw_if.tick_adj    = ta;
    sw_if.pause_pulse = pp;
    sw_if.clear_pulse = cp;
    @(negedge clk);
    sw_if.tick_1hz    = 1'b0;
    sw_if.tick_adj    = 1'b0;
    sw_if.pause_pulse = 1'b0;
    sw_if.clear_pulse = 1'b0;
  endtask

  function automatic logic [15:0] digits();
    return {sw_if.digit_1, sw_if.digit_2, sw_if.digit_3, sw_if.digit_4};
  endfunction

  task automatic check_digits(input string name, input logic [15:0] exp);
    total++;
    if (digits() !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, digits(), exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Preload MM:SS through adjust mode from 00:00, leaving adj=0.
  task automatic preload(input int mm, input int ss);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    sw_if.adj = 1'b1;
    sw_if.sel = 1'b0;
    for (int i = 0; i < mm; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    sw_if.sel = 1'b1;
    for (int i = 0; i < ss; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    sw_if.adj = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    check_digits("reset_digits", 16'h0000);
    check_bit("reset_pause_mode", sw_if.pause_mode, 1'b0);
    check_bit("reset_reg_mode", sw_if.reg_mode, 1'b1);
    check_bit("reset_adj_sec_mode", sw_if.adj_sec_mode, 1'b0);
    check_bit("reset_adj_min_mode", sw_if.adj_min_mode, 1'b0);
    check_bit("reset_wrap", sw_if.wrap, 1'b0);
  endtask

  task automatic test_count();
    int wrap_hits = 0;
    for (int i = 0; i < 75; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (sw_if.wrap === 1'b1) wrap_hits++;
    end
    check_digits("count_75", 16'h0115);
    total++;
    if (wrap_hits != 0) begin
      bad++;
      $display("FAIL count_no_wrap: got %0d wrap cycles expected 0", wrap_hits);
    end
    check_bit("count_reg_mode", sw_if.reg_mode, 1'b1);
  endtask

  task automatic test_wrap();
    preload(59, 58);
    check_digits("wrap_preload", 16'h5958);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_digits("wrap_5959", 16'h5959);
    check_bit("wrap_low_before", sw_if.wrap, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_digits("wrap_0000", 16'h0000);
    check_bit("wrap_pulse", sw_if.wrap, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_bit("wrap_one_cycle", sw_if.wrap, 1'b0);
  endtask

  task automatic test_pause();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check_digits("pause_at_0010", 16'h0010);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_bit("pause_mode_set", sw_if.pause_mode, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check_digits("pause_hold", 16'h0010);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check_digits("pause_tick_gated_by_old", 16'h0010);
    check_bit("pause_mode_cleared", sw_if.pause_mode, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_digits("pause_resume", 16'h0011);
  endtask

  task automatic test_adj_sec();
    preload(0, 58);
    sw_if.adj = 1'b1;
    sw_if.sel = 1'b1;
    check_bit("adj_sec_mode_latency", sw_if.adj_sec_mode, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_bit("adj_sec_mode_set", sw_if.adj_sec_mode, 1'b1);
    check_bit("adj_reg_mode_clr", sw_if.reg_mode, 1'b0);
    check_digits("adj_tick1hz_ignored", 16'h0058);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check_bit("adj_sec_no_wrap", sw_if.wrap, 1'b0);
    end
    check_digits("adj_sec_0001", 16'h0001);
    sw_if.adj = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_adj_min();
    preload(59, 30);
    sw_if.adj = 1'b1;
    sw_if.sel = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_digits("adj_min_wrap_0030", 16'h0030);
    check_bit("adj_min_no_wrap", sw_if.wrap, 1'b0);
    check_bit("adj_min_mode_set", sw_if.adj_min_mode, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check_digits("clear_beats_adjust", 16'h0000);
    sw_if.adj = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_digits("leave_adj_counts", 16'h0001);
  endtask

  task automatic test_back_to_back();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check_digits("back_to_back_12", 16'h0012);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_digits("clear_beats_count", 16'h0000);
  endtask

  task automatic test_async_reset();
    preload(12, 34);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_digits("async_preload", 16'h1234);
    check_bit("async_paused", sw_if.pause_mode, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_digits("async_digits", 16'h0000);
    check_bit("async_pause_mode", sw_if.pause_mode, 1'b0);
    check_bit("async_reg_mode", sw_if.reg_mode, 1'b1);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_digits("async_hold_no_tick", 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_digits("async_first_count", 16'h0001);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    sw_if.tick_1hz    = 1'b0;
    sw_if.tick_adj    = 1'b0;
    sw_if.adj         = 1'b0;
    sw_if.sel         = 1'b0;
    sw_if.pause_pulse = 1'b0;
    sw_if.clear_pulse = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_count();
    test_wrap();
    test_pause();
    test_adj_sec();
    test_adj_min();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
